mc_controller: RTL and testbench
================================

# mc_controller

Multicycle MIPS control unit driving the 32-bit ALU and the surrounding datapath: it sequences fetch, decode, execute, memory and writeback over 3–5 clocks per instruction. It is a Moore FSM plus an ALU-operation decoder, and it generates the 3-bit `ALUControl` the ALU consumes. It also consumes the ALU's `zero` flag to resolve branches.

## Interface
- No parameters; all widths are fixed by the MIPS ISA.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Op` in 6: instruction bits [31:26], valid from the cycle after `IRWrite`.
- `Funct` in 6: instruction bits [5:0].
- `Zero` in 1: ALU `zero` flag, combinational from the current cycle's ALU result.
- `IorD` out 1: memory address source. 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: 0 = rt, 1 = rd.
- `MemtoReg` out 1: 0 = ALUOut, 1 = Data register.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 2: 00 = PC, 01 = A register, 10 = zero-extended shamt.
- `ALUSrcB` out 2: 00 = B register, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl` out 3: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLL (SrcB<<SrcA), 5 SRL, 6 SLT, 7 yields 0.
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target {PC[31:28], instr[25:0], 2'b00}.
- `PCEn` out 1: PC load, computed as PCWrite | (Branch & Zero).

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- FETCH
  - Outputs: IorD=0, IRWrite=1, ALUSrcA=00, ALUSrcB=01, ALUControl=ADD, PCSrc=00, PCWrite=1.
  - Next state: DECODE.
- DECODE
  - Outputs: ALUSrcA=00, ALUSrcB=11, ALUControl=ADD (branch target into ALUOut).
- Transitions out of DECODE, by `Op`:
  - 100011 lw and 101011 sw go to MEMADR.
  - 000000 R-type goes to RTYPEEX.
  - 000100 beq goes to BEQEX.
  - 001000 addi goes to ADDIEX.
  - 000010 j goes to JEX.
  - Any other opcode goes to FETCH and is treated as a NOP: no write enable is asserted.
- MEMADR
  - Outputs: ALUSrcA=01, ALUSrcB=10, ADD.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEMWR: IorD=1, MemWrite=1, then FETCH.
- RTYPEEX
  - ALUSrcB=00.
  - ALUSrcA=10 for sll/srl, 01 otherwise.
  - ALUControl comes from `Funct`: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL, 000010 SRL.
  - An unknown funct gives 7; the result 0 is written back.
- RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- BEQEX
  - Outputs: ALUSrcA=01, ALUSrcB=00, SUB, PCSrc=01, Branch=1.
  - PCEn = Zero in this cycle. Next state: FETCH.
- ADDIEX: ALUSrcA=01, ALUSrcB=10, ADD, then ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- JEX: PCSrc=10, PCWrite=1, then FETCH.
- In every state, any output not listed is 0; ALUSrcA, ALUSrcB and PCSrc default to 00.

## Timing
- The state register updates on the rising edge of `clk`. All outputs except `PCEn` are pure functions of state and the latched `Op`/`Funct`. `PCEn` also depends combinationally on `Zero`.
- Latency from entering FETCH to re-entering FETCH:
  - lw: 5 clocks.
  - sw, R-type and addi: 4 clocks.
  - beq and j: 3 clocks.
  - Unknown opcode: 2 clocks.
- Reset has priority over all transitions: `reset`=1 at an edge puts the state in FETCH, from any state including mid-instruction.
- While `reset`=1, IRWrite, PCEn, RegWrite and MemWrite are forced to 0; every other output takes its FETCH value. This is also the reset value of every output.
- After `reset` deasserts, the first FETCH performs the fetch.
- `Zero` is sampled only in BEQEX; its value in every other state is ignored.

## Configuration
- `MC_CTRL_BNE_EN`
  - Defined: opcode 000101 (bne) goes DECODE→BEQEX, with PCEn = ~Zero instead of Zero. The decoded branch polarity is held for that cycle.
  - Undefined: 000101 is an unknown opcode and is treated as a NOP (DECODE→FETCH).

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum (4-bit);
  - the opcode and funct localparams;
  - the ALUControl code constants (0–7);
  - the ALUSrcA, ALUSrcB and PCSrc encodings.
- Sub-module `alu_decoder` is combinational. Inputs: ALUOp (2 bits: 00 ADD, 01 SUB, 10 funct-decoded) and Funct. Outputs: ALUControl and a shift flag that selects ALUSrcA=10.
- The top module holds the state register, next-state logic, output decode and PCEn gating.

## Test plan
- Reset mid-MEMRD of lw, `reset`=1 for one edge: the state is FETCH; IRWrite, PCEn, RegWrite and MemWrite stay 0 while reset is high.
- lw (Op=100011): the state sequence is FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. RegWrite=1 and MemtoReg=1 appear only in cycle 5.
- R-type sll (Op=0, Funct=000000): in RTYPEEX, ALUControl=4, ALUSrcA=10, ALUSrcB=00. In RTYPEWB, RegDst=1 and RegWrite=1.
- beq (Op=000100) with Zero=1 then Zero=0: in BEQEX, PCEn=1 with PCSrc=01 in the first case and PCEn=0 in the second. Both return to FETCH after 3 clocks.
- Unknown Op=111111: DECODE goes to FETCH with no write enable asserted. With Funct=111111 on an R-type, ALUControl=7 in RTYPEEX.
- With `MC_CTRL_BNE_EN`: Op=000101 with Zero=0 gives PCEn=1. Without the macro, the same opcode takes the NOP path.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: the FSM state
// encoding, the opcode and funct values the controller decodes, the 3-bit
// ALUControl codes and the datapath mux encodings for ALUSrcA, ALUSrcB and
// PCSrc.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct codes (instruction bits [5:0]) for R-type instructions
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl codes consumed by the ALU
  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_SLL  = 3'd4;
  localparam logic [2:0] ALU_SRL  = 3'd5;
  localparam logic [2:0] ALU_SLT  = 3'd6;
  localparam logic [2:0] ALU_ZERO = 3'd7;

  // ALUOp handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU source A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  // ALU source B select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder
// Combinational translation of the FSM's ALUOp request into the 3-bit
// ALUControl code. For funct-decoded operations it also flags the shifts,
// whose A operand must come from the shamt field instead of register A.
// Ports:
//   i_aluOp       in  2 : 00 ADD, 01 SUB, 10 decode from funct
//   i_funct       in  6 : instruction funct field
//   o_aluControl  out 3 : ALU operation code
//   o_shift       out 1 : 1 when the decoded op is sll/srl
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] i_aluOp,
  input  logic [5:0] i_funct,
  output logic [2:0] o_aluControl,
  output logic       o_shift
);

  // Fixed ADD/SUB requests pass straight through; R-type requests are
  // decoded from funct, with any unrecognised funct producing the code
  // that makes the ALU output 0 so the writeback is harmless.
  always_comb begin
    o_aluControl = ALU_AND;
    o_shift      = 1'b0;
    case (i_aluOp)
      ALUOP_ADD: o_aluControl = ALU_ADD;
      ALUOP_SUB: o_aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD: o_aluControl = ALU_ADD;
          FN_SUB: o_aluControl = ALU_SUB;
          FN_AND: o_aluControl = ALU_AND;
          FN_OR:  o_aluControl = ALU_OR;
          FN_SLT: o_aluControl = ALU_SLT;
          FN_SLL: begin
            o_aluControl = ALU_SLL;
            o_shift      = 1'b1;
          end
          FN_SRL: begin
            o_aluControl = ALU_SRL;
            o_shift      = 1'b1;
          end
          default: o_aluControl = ALU_ZERO;
        endcase
      end
      default: o_aluControl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
// Multicycle MIPS control unit. A Moore FSM sequences fetch, decode,
// execute, memory and writeback (3-5 clocks per instruction) and an ALU
// decoder produces ALUControl. PCEn additionally gates the branch decision
// with the ALU Zero flag in the same cycle.
// Optional feature macro: MC_CTRL_BNE_EN adds bne (opcode 000101), which
// reuses the BEQEX state with inverted Zero polarity.
// Ports:
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_op, i_funct        : instruction [31:26] and [5:0]
//   i_zero               : ALU zero flag of the current cycle
//   o_iOrD               : memory address 0=PC 1=ALUOut
//   o_memWrite           : data memory write enable
//   o_irWrite            : instruction register load
//   o_regDst             : register destination 0=rt 1=rd
//   o_memToReg           : writeback source 0=ALUOut 1=Data
//   o_regWrite           : register file write enable
//   o_aluSrcA [1:0]      : 00 PC, 01 A, 10 shamt
//   o_aluSrcB [1:0]      : 00 B, 01 4, 10 SignImm, 11 SignImm<<2
//   o_aluControl [2:0]   : ALU operation
//   o_pcSrc [1:0]        : 00 ALUResult, 01 ALUOut, 10 jump target
//   o_pcEn               : PC load = PCWrite | (Branch & taken)
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  output logic       o_iOrD,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_regDst,
  output logic       o_memToReg,
  output logic       o_regWrite,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [2:0] o_aluControl,
  output logic [1:0] o_pcSrc,
  output logic       o_pcEn
);

  state_t     r_state;
  state_t     w_nextState;
  logic [1:0] w_aluOp;
  logic [2:0] w_decAluControl;
  logic       w_shift;
  logic       w_pcWrite;
  logic       w_branch;
  logic       w_branchTaken;

  // State register; reset wins over every transition, even mid-instruction.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

`ifdef MC_CTRL_BNE_EN
  logic r_bne;

  // Remember whether DECODE saw bne so BEQEX can invert the Zero test;
  // the opcode is decoded once and held for the execute cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bne <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_bne <= (i_op == OP_BNE);
    end
  end

  assign w_branchTaken = r_bne ? ~i_zero : i_zero;
`else
  assign w_branchTaken = i_zero;
`endif

  // Next-state logic. Unknown opcodes fall back to FETCH from DECODE, which
  // asserts no write enable, so they behave as a two-cycle NOP.
  always_comb begin
    w_nextState = S_FETCH;
    case (r_state)
      S_FETCH:  w_nextState = S_DECODE;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: w_nextState = S_MEMADR;
          OP_RTYPE:     w_nextState = S_RTYPEEX;
          OP_BEQ:       w_nextState = S_BEQEX;
          OP_ADDI:      w_nextState = S_ADDIEX;
          OP_J:         w_nextState = S_JEX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       w_nextState = S_BEQEX;
`endif
          default:      w_nextState = S_FETCH;
        endcase
      end
      S_MEMADR:  w_nextState = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_nextState = S_MEMWB;
      S_RTYPEEX: w_nextState = S_RTYPEWB;
      S_ADDIEX:  w_nextState = S_ADDIWB;
      default:   w_nextState = S_FETCH;
    endcase
  end

  // ALUOp is a pure function of state; kept apart from the output decode so
  // the decoder's shift flag does not feed back into the block that drives it.
  always_comb begin
    w_aluOp = ALUOP_ADD;
    case (r_state)
      S_RTYPEEX: w_aluOp = ALUOP_FUNCT;
      S_BEQEX:   w_aluOp = ALUOP_SUB;
      default:   w_aluOp = ALUOP_ADD;
    endcase
  end

  alu_decoder u_aluDecoder (
    .i_aluOp      (w_aluOp),
    .i_funct      (i_funct),
    .o_aluControl (w_decAluControl),
    .o_shift      (w_shift)
  );

  // Moore output decode. While reset is held, outputs show FETCH values with
  // all write enables (including PCWrite) suppressed.
  always_comb begin
    o_iOrD       = 1'b0;
    o_memWrite   = 1'b0;
    o_irWrite    = 1'b0;
    o_regDst     = 1'b0;
    o_memToReg   = 1'b0;
    o_regWrite   = 1'b0;
    o_aluSrcA    = SRCA_PC;
    o_aluSrcB    = SRCB_REG;
    o_aluControl = ALU_AND;
    o_pcSrc      = PCSRC_ALU;
    w_pcWrite    = 1'b0;
    w_branch     = 1'b0;
    if (i_reset) begin
      o_aluSrcB    = SRCB_FOUR;
      o_aluControl = ALU_ADD;
    end else begin
      case (r_state)
        S_FETCH: begin
          o_irWrite    = 1'b1;
          o_aluSrcB    = SRCB_FOUR;
          o_aluControl = w_decAluControl;
          w_pcWrite    = 1'b1;
        end
        S_DECODE: begin
          o_aluSrcB    = SRCB_IMMSH;
          o_aluControl = w_decAluControl;
        end
        S_MEMADR, S_ADDIEX: begin
          o_aluSrcA    = SRCA_REG;
          o_aluSrcB    = SRCB_IMM;
          o_aluControl = w_decAluControl;
        end
        S_MEMRD: o_iOrD = 1'b1;
        S_MEMWB: begin
          o_memToReg = 1'b1;
          o_regWrite = 1'b1;
        end
        S_MEMWR: begin
          o_iOrD     = 1'b1;
          o_memWrite = 1'b1;
        end
        S_RTYPEEX: begin
          o_aluSrcA    = w_shift ? SRCA_SHAMT : SRCA_REG;
          o_aluSrcB    = SRCB_REG;
          o_aluControl = w_decAluControl;
        end
        S_RTYPEWB: begin
          o_regDst   = 1'b1;
          o_regWrite = 1'b1;
        end
        S_BEQEX: begin
          o_aluSrcA    = SRCA_REG;
          o_aluSrcB    = SRCB_REG;
          o_aluControl = w_decAluControl;
          o_pcSrc      = PCSRC_ALUOUT;
          w_branch     = 1'b1;
        end
        S_ADDIWB: o_regWrite = 1'b1;
        S_JEX: begin
          o_pcSrc   = PCSRC_JUMP;
          w_pcWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_pcEn = w_pcWrite | (w_branch & w_branchTaken);

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
// Self-checking bench for mc_controller. Each instruction is classified
// from its opcode and checked for cycle count, write-enable counts and
// placement, PC load count and source, and execute-cycle ALU setup.
// Honours MC_CTRL_BNE_EN the same way the design does.
module tb_mc_controller;

`ifdef MC_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef enum {K_LW, K_SW, K_R, K_BEQ, K_BNE, K_ADDI, K_J, K_NOP} kind_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iOrD, memWrite, irWrite, regDst, memToReg, regWrite, pcEn;
  logic [1:0] aluSrcA, aluSrcB, pcSrc;
  logic [2:0] aluControl;

  int checks   = 0;
  int failures = 0;

  mc_controller dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_op         (op),
    .i_funct      (funct),
    .i_zero       (zero),
    .o_iOrD       (iOrD),
    .o_memWrite   (memWrite),
    .o_irWrite    (irWrite),
    .o_regDst     (regDst),
    .o_memToReg   (memToReg),
    .o_regWrite   (regWrite),
    .o_aluSrcA    (aluSrcA),
    .o_aluSrcB    (aluSrcB),
    .o_aluControl (aluControl),
    .o_pcSrc      (pcSrc),
    .o_pcEn       (pcEn)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Instruction class from the opcode alone
  function automatic kind_t classify(input logic [5:0] o);
    case (o)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return K_R;
      6'b000100: return K_BEQ;
      6'b000101: return BNE_EN ? K_BNE : K_NOP;
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
      default:   return K_NOP;
    endcase
  endfunction

  function automatic int expLatency(input kind_t k);
    case (k)
      K_LW:                return 5;
      K_SW, K_R, K_ADDI:   return 4;
      K_BEQ, K_BNE, K_J:   return 3;
      default:             return 2;
    endcase
  endfunction

  function automatic int expFunctAlu(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 3;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 6;
      6'b000000: return 4;
      6'b000010: return 5;
      default:   return 7;
    endcase
  endfunction

  // Run one instruction starting at a falling edge in FETCH, observing each
  // cycle until the next fetch, then compare against the model.
  task automatic applyStimulus(input logic [5:0] opIn, input logic [5:0] functIn,
                               input logic zeroIn);
    kind_t k;
    int cyc, lat, regW, memW, pcE, wrCyc, expPcE, expAlu, expSrcA, expSrcB;
    int takenSrc, decSrcB, execAlu, execSrcA, execSrcB;
    logic wrDst, wrM2R, done;
    string id;
    k = classify(opIn);
    op = opIn; funct = functIn; zero = zeroIn;
    id = $sformatf("op=%b fn=%b z=%0d", opIn, functIn, zeroIn);
    cyc = 1; done = 1'b0; regW = 0; memW = 0; pcE = 0; wrCyc = 0;
    takenSrc = -1; decSrcB = -1; execAlu = -1; execSrcA = -1; execSrcB = -1;
    wrDst = 1'b0; wrM2R = 1'b0;
    #1;
    while (!done && cyc <= 9) begin
      if (cyc > 1 && irWrite === 1'b1) begin
        done = 1'b1;
      end else begin
        regW += int'(regWrite);
        memW += int'(memWrite);
        pcE  += int'(pcEn);
        if (regWrite) begin
          wrCyc = cyc; wrDst = regDst; wrM2R = memToReg;
        end
        if (pcEn && cyc > 1) takenSrc = int'(pcSrc);
        if (cyc == 2) decSrcB = int'(aluSrcB);
        if (cyc == 3) begin
          execAlu = int'(aluControl); execSrcA = int'(aluSrcA); execSrcB = int'(aluSrcB);
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      checkOutput({"timeout ", id}, 32'd0, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    lat = cyc - 1;
    checkOutput({"latency ", id}, lat, expLatency(k));
    checkOutput({"decodeSrcB ", id}, decSrcB, 3);
    checkOutput({"regWriteCount ", id}, regW, (k == K_LW || k == K_R || k == K_ADDI) ? 1 : 0);
    checkOutput({"memWriteCount ", id}, memW, (k == K_SW) ? 1 : 0);
    expPcE = 1 + ((k == K_J) ? 1 : 0) + ((k == K_BEQ && zeroIn) ? 1 : 0)
               + ((k == K_BNE && !zeroIn) ? 1 : 0);
    checkOutput({"pcEnCount ", id}, pcE, expPcE);
    if (expPcE > 1) checkOutput({"pcSrc ", id}, takenSrc, (k == K_J) ? 2 : 1);
    if (regW > 0) begin
      checkOutput({"writeCycle ", id}, wrCyc, expLatency(k));
      checkOutput({"regDst ", id}, 32'(wrDst), (k == K_R) ? 1 : 0);
      checkOutput({"memToReg ", id}, 32'(wrM2R), (k == K_LW) ? 1 : 0);
    end
    if (k != K_NOP) begin
      case (k)
        K_R:          expAlu = expFunctAlu(functIn);
        K_BEQ, K_BNE: expAlu = 3;
        K_J:          expAlu = 0;
        default:      expAlu = 2;
      endcase
      expSrcA = (k == K_J) ? 0 :
                (k == K_R && (functIn == 6'b000000 || functIn == 6'b000010)) ? 2 : 1;
      expSrcB = (k == K_LW || k == K_SW || k == K_ADDI) ? 2 : 0;
      checkOutput({"execAlu ", id}, execAlu, expAlu);
      checkOutput({"execSrcA ", id}, execSrcA, expSrcA);
      checkOutput({"execSrcB ", id}, execSrcB, expSrcB);
    end
  endtask

  logic [5:0] opTable [8];
  logic [5:0] fnTable [8];

  initial begin
    opTable = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b000101, 6'b000000};
    fnTable = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b101010, 6'b000000, 6'b000010, 6'b000000};
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values: FETCH outputs with every enable forced low
    checkOutput("rst irWrite", 32'(irWrite), 0);
    checkOutput("rst pcEn", 32'(pcEn), 0);
    checkOutput("rst regWrite", 32'(regWrite), 0);
    checkOutput("rst memWrite", 32'(memWrite), 0);
    checkOutput("rst iOrD", 32'(iOrD), 0);
    checkOutput("rst aluSrcA", 32'(aluSrcA), 0);
    checkOutput("rst aluSrcB", 32'(aluSrcB), 1);
    checkOutput("rst aluControl", 32'(aluControl), 2);
    checkOutput("rst pcSrc", 32'(pcSrc), 0);

    reset = 1'b0;
    #1;
    checkOutput("fetch irWrite", 32'(irWrite), 1);
    checkOutput("fetch pcEn", 32'(pcEn), 1);

    // Reset while lw sits in MEMRD
    op = 6'b100011; funct = 6'd0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("memrd iOrD", 32'(iOrD), 1);
    reset = 1'b1;
    #1;
    checkOutput("rstMid iOrD", 32'(iOrD), 0);
    checkOutput("rstMid regWrite", 32'(regWrite), 0);
    checkOutput("rstMid memWrite", 32'(memWrite), 0);
    @(posedge clk);
    #1;
    checkOutput("rstHeld irWrite", 32'(irWrite), 0);
    checkOutput("rstHeld pcEn", 32'(pcEn), 0);
    checkOutput("rstHeld aluSrcB", 32'(aluSrcB), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("postRst irWrite", 32'(irWrite), 1);
    checkOutput("postRst pcEn", 32'(pcEn), 1);

    // Directed cases
    applyStimulus(6'b100011, 6'b000000, 1'b0);  // lw
    applyStimulus(6'b000000, 6'b000000, 1'b0);  // sll
    applyStimulus(6'b000000, 6'b000010, 1'b1);  // srl
    applyStimulus(6'b000100, 6'b000000, 1'b1);  // beq taken
    applyStimulus(6'b000100, 6'b000000, 1'b0);  // beq not taken
    applyStimulus(6'b111111, 6'b000000, 1'b1);  // unknown opcode
    applyStimulus(6'b000000, 6'b111111, 1'b0);  // unknown funct
    applyStimulus(6'b000101, 6'b000000, 1'b0);  // bne or NOP
    applyStimulus(6'b000101, 6'b000000, 1'b1);
    applyStimulus(6'b101011, 6'b000000, 1'b1);  // sw
    applyStimulus(6'b001000, 6'b000000, 1'b0);  // addi
    applyStimulus(6'b000010, 6'b000000, 1'b1);  // j

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      int so, sf;
      logic [5:0] ro, rf;
      so = $urandom_range(0, 7);
      sf = $urandom_range(0, 7);
      ro = (so == 7) ? 6'($urandom) : opTable[so];
      rf = (sf == 7) ? 6'($urandom) : fnTable[sf];
      applyStimulus(ro, rf, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
